// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ISA opcodes, CPU run-state constants and MEM-stage FSM type
package cpu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_STORE = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR    = 5'b00110;
  localparam logic [OPC_W-1:0] OP_XOR   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_LDI   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_BZ    = 5'b01011;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'b01100;
  localparam logic [OPC_W-1:0] OP_HALT  = 5'b11111;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EXEC = 1'b1;

  typedef enum logic {
    RUN       = 1'b0,
    MISS_WAIT = 1'b1
  } mem_fsm_t;

endpackage

// File: rtl/mem_perf_counters.sv
// rtl/mem_perf_counters.sv - four saturating event counters (load, store, hit, miss)
module mem_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_inc,
  input  logic             store_inc,
  input  logic             hit_inc,
  input  logic             miss_inc,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (load_inc  && (load_cnt  != '1)) load_cnt  <= load_cnt  + 1'b1;
      if (store_inc && (store_cnt != '1)) store_cnt <= store_cnt + 1'b1;
      if (hit_inc   && (hit_cnt   != '1)) hit_cnt   <= hit_cnt   + 1'b1;
      if (miss_inc  && (miss_cnt  != '1)) miss_cnt  <= miss_cnt  + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage write-back select with load-miss stall; counters under MEM_PERF_CNT_EN
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int IR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic [IR_W-1:0]   mem_ir,
  input  logic [DATA_W-1:0] reg_C,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_data,
  input  logic [DATA_W-1:0] d_datain,
  input  logic              d_ready,
  output logic [IR_W-1:0]   wb_ir,
  output logic [DATA_W-1:0] reg_C1,
  output logic              stall,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  mem_fsm_t          fsm, fsm_next;
  logic [IR_W-1:0]   held_ir, held_ir_next;
  logic [IR_W-1:0]   wb_ir_next;
  logic [DATA_W-1:0] reg_C1_next;

  logic [OPC_W-1:0] opcode;
  logic             exec_run;
  logic             is_load;

  assign opcode   = mem_ir[IR_W-1 -: OPC_W];
  assign exec_run = (state == ST_EXEC) && (fsm == RUN);
  assign is_load  = (opcode == OP_LOAD);

  assign stall = (fsm == MISS_WAIT) || (exec_run && is_load && !cache_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm     <= RUN;
      held_ir <= '0;
      wb_ir   <= '0;
      reg_C1  <= '0;
    end else begin
      fsm     <= fsm_next;
      held_ir <= held_ir_next;
      wb_ir   <= wb_ir_next;
      reg_C1  <= reg_C1_next;
    end
  end

  always_comb begin
    fsm_next     = fsm;
    held_ir_next = held_ir;
    wb_ir_next   = wb_ir;
    reg_C1_next  = reg_C1;
    if (state == ST_EXEC) begin
      case (fsm)
        RUN: begin
          if (is_load && !cache_hit) begin
            // Park the load and send a bubble down while memory answers.
            held_ir_next = mem_ir;
            wb_ir_next   = '0;
            fsm_next     = MISS_WAIT;
          end else if (is_load) begin
            wb_ir_next  = mem_ir;
            reg_C1_next = cache_data;
          end else begin
            wb_ir_next  = mem_ir;
            reg_C1_next = reg_C;
          end
        end
        MISS_WAIT: begin
          if (d_ready) begin
            wb_ir_next  = held_ir;
            reg_C1_next = d_datain;
            fsm_next    = RUN;
          end else begin
            wb_ir_next  = '0;
          end
        end
        default: fsm_next = RUN;
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  logic ev_load, ev_store, ev_hit, ev_miss;

  assign ev_load  = exec_run && is_load;
  assign ev_store = exec_run && (opcode == OP_STORE);
  assign ev_hit   = ev_load && cache_hit;
  assign ev_miss  = ev_load && !cache_hit;

  mem_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clock     (clock),
    .reset     (reset),
    .load_inc  (ev_load),
    .store_inc (ev_store),
    .hit_inc   (ev_hit),
    .miss_inc  (ev_miss),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );
`else
  assign load_cnt  = '0;
  assign store_cnt = '0;
  assign hit_cnt   = '0;
  assign miss_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized bench with behavioural MEM-stage model and literal anchors
module tb_mem_stage_ctrl;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam int IR_W   = 16;
  localparam logic [4:0] NOP = 5'b00000, ADD = 5'b00001, LOAD = 5'b00010, STORE = 5'b00011;
`ifdef MEM_PERF_CNT_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset, state, cache_hit, d_ready;
  logic [IR_W-1:0]   mem_ir;
  logic [DATA_W-1:0] reg_C, cache_data, d_datain;
  logic [IR_W-1:0]   wb_ir;
  logic [DATA_W-1:0] reg_C1;
  logic              stall;
  logic [CNT_W-1:0]  load_cnt, store_cnt, hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_stage_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IR_W(IR_W)) dut (
    .clock(clock), .reset(reset), .state(state), .mem_ir(mem_ir), .reg_C(reg_C),
    .cache_hit(cache_hit), .cache_data(cache_data), .d_datain(d_datain), .d_ready(d_ready),
    .wb_ir(wb_ir), .reg_C1(reg_C1), .stall(stall),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "waiting for memory" flag, pending load, and event tallies.
  bit              armed = 0;
  bit              m_wait = 0;
  logic [IR_W-1:0] m_held = '0, m_wb = '0;
  logic [DATA_W-1:0] m_c1 = '0;
  int n_load = 0, n_store = 0, n_hit = 0, n_miss = 0;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_wait = 0; m_held = '0; m_wb = '0; m_c1 = '0;
      n_load = 0; n_store = 0; n_hit = 0; n_miss = 0;
    end else if (state) begin
      if (!m_wait) begin
        if (mem_ir[15:11] == LOAD) begin
          n_load = sat(n_load);
          if (cache_hit) begin
            m_wb = mem_ir; m_c1 = cache_data; n_hit = sat(n_hit);
          end else begin
            m_held = mem_ir; m_wb = '0; m_wait = 1; n_miss = sat(n_miss);
          end
        end else begin
          m_wb = mem_ir; m_c1 = reg_C;
          if (mem_ir[15:11] == STORE) n_store = sat(n_store);
        end
      end else if (d_ready) begin
        m_wb = m_held; m_c1 = d_datain; m_wait = 0;
      end else begin
        m_wb = '0;
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("wb_ir", 32'(wb_ir), 32'(m_wb));
      chk("reg_C1", 32'(reg_C1), 32'(m_c1));
      chk("stall", 32'(stall),
          32'(m_wait || (state && mem_ir[15:11] == LOAD && !cache_hit)));
      chk("load_cnt", 32'(load_cnt), 32'(PE * n_load));
      chk("store_cnt", 32'(store_cnt), 32'(PE * n_store));
      chk("hit_cnt", 32'(hit_cnt), 32'(PE * n_hit));
      chk("miss_cnt", 32'(miss_cnt), 32'(PE * n_miss));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [IR_W-1:0] ld_ir;
  int n_stall;

  initial begin
    reset = 1; state = 0; mem_ir = '0; reg_C = '0; cache_hit = 0;
    cache_data = '0; d_datain = '0; d_ready = 0;
    tick(); tick();
    armed = 1;
    reset = 0;
    chk("rst_wb_ir", 32'(wb_ir), 0);
    chk("rst_reg_C1", 32'(reg_C1), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_load_cnt", 32'(load_cnt), 0);

    // ALU pass-through
    state = 1; mem_ir = {ADD, 11'h005}; reg_C = 16'h1234;
    tick();
    chk("add_wb_ir", 32'(wb_ir), 32'h0805);
    chk("add_reg_C1", 32'(reg_C1), 32'h1234);
    chk("add_stall", 32'(stall), 0);

    // load hit
    mem_ir = {LOAD, 11'h015}; cache_hit = 1; cache_data = 16'hBEEF;
    tick();
    chk("hit_reg_C1", 32'(reg_C1), 32'hBEEF);
    chk("hit_wb_ir", 32'(wb_ir), 32'h1015);
    chk("hit_load_cnt", 32'(load_cnt), PE);
    chk("hit_hit_cnt", 32'(hit_cnt), PE);

    // load miss, memory answers on the fourth stalled cycle
    ld_ir = {LOAD, 11'h02A};
    mem_ir = ld_ir; cache_hit = 0; d_datain = 16'hCAFE; n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      d_ready = (i == 3);
      @(negedge clock);
      if (stall) n_stall++;
      tick();
      mem_ir = {ADD, 11'h001}; cache_hit = 1;
    end
    chk("miss_stall_cycles", n_stall, 4);
    chk("miss_wb_ir", 32'(wb_ir), 32'(ld_ir));
    chk("miss_reg_C1", 32'(reg_C1), 32'hCAFE);
    chk("miss_miss_cnt", 32'(miss_cnt), PE);

    // miss held across idle cycles
    d_ready = 0; mem_ir = ld_ir; cache_hit = 0;
    tick();
    state = 0; d_ready = 1; d_datain = 16'h1111; mem_ir = {NOP, 11'h0};
    tick();
    chk("idle1_wb_ir", 32'(wb_ir), 0);
    chk("idle1_stall", 32'(stall), 1);
    tick();
    chk("idle2_wb_ir", 32'(wb_ir), 0);
    chk("idle2_reg_C1", 32'(reg_C1), 32'hCAFE);
    state = 1;
    tick();
    chk("idle_done_wb_ir", 32'(wb_ir), 32'(ld_ir));
    chk("idle_done_reg_C1", 32'(reg_C1), 32'h1111);

    // reset abandons a pending miss
    mem_ir = ld_ir; cache_hit = 0; d_ready = 0;
    tick();
    reset = 1; mem_ir = '0;
    tick();
    reset = 0;
    chk("rstmiss_stall", 32'(stall), 0);
    chk("rstmiss_wb_ir", 32'(wb_ir), 0);
    chk("rstmiss_reg_C1", 32'(reg_C1), 0);
    chk("rstmiss_miss_cnt", 32'(miss_cnt), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      state = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 3))
        0: mem_ir = {LOAD, 11'($urandom)};
        1: mem_ir = {STORE, 11'($urandom)};
        default: mem_ir = 16'($urandom);
      endcase
      reg_C = 16'($urandom); cache_data = 16'($urandom); d_datain = 16'($urandom);
      cache_hit = $urandom_range(0, 1) == 1;
      d_ready = ($urandom_range(0, 9) < 3);
      tick();
    end

    // store counter saturation
    reset = 1; tick();
    reset = 0; state = 1; mem_ir = {STORE, 11'h7FF}; d_ready = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_store_cnt", 32'(store_cnt), PE * 15);
    chk("sat_load_cnt", 32'(load_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
